// File: rtl/lfsr_gen_if.sv
// ---------------------------------------------------------------------------
// lfsr_gen_if -- control/observation bundle for the lfsr_gen core.
//
// The master side (the user of the sequence) drives the step/load controls.
// The slave side (the LFSR core) returns the current state, serial output,
// event pulses and the measured period.
//
//   en            master -> slave  advance one step this cycle
//   load          master -> slave  load seed_in this cycle (beats en)
//   seed_in       master -> slave  runtime seed, WIDTH bits, loaded verbatim
//   q             slave -> master  current LFSR state, WIDTH bits
//   msb           slave -> master  q[WIDTH-1], serial output
//   wrap_tick     slave -> master  1-cycle pulse: state returned to the reference seed
//   lockup        slave -> master  1-cycle pulse: lock-up state detected and recovered
//   period        slave -> master  steps in the last completed seed-to-seed cycle
//   period_valid  slave -> master  period holds a measured value
// ---------------------------------------------------------------------------
interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 19
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] q;
  logic             msb;
  logic             wrap_tick;
  logic             lockup;
  logic [WIDTH-1:0] period;
  logic             period_valid;

  modport master (
    output en, load, seed_in,
    input  q, msb, wrap_tick, lockup, period, period_valid
  );

  modport slave (
    input  en, load, seed_in,
    output q, msb, wrap_tick, lockup, period, period_valid
  );
endinterface : lfsr_gen_if

// File: rtl/lfsr_gen.sv
// ---------------------------------------------------------------------------
// lfsr_gen -- parametrised LFSR sequence source.
//
// Generic width and tap mask, Fibonacci (external XOR) or Galois (internal
// XOR) form, XOR or XNOR feedback. Supports a runtime seed load, detects the
// lock-up state and recovers to SEED, and measures the length of each
// completed seed-to-seed cycle.
//
// Parameters
//   WIDTH   register width, 3..32
//   TAPS    tap mask, bit k set = stage k in the feedback; bit WIDTH-1 set
//   SEED    reset / recovery value, never the lock-up state
//   GALOIS  0 = Fibonacci, 1 = Galois
//   XNOR    0 = XOR feedback (lock-up all-0), 1 = XNOR feedback (lock-up all-1)
//
// Ports
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    lfsr_gen_if.slave: en/load/seed_in in; q, msb, wrap_tick,
//          lockup, period, period_valid out (all registered)
// ---------------------------------------------------------------------------
module lfsr_gen #(
  parameter int unsigned      WIDTH  = 19,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(19'h40023),
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
  parameter bit               GALOIS = 1'b0,
  parameter bit               XNOR   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  lfsr_gen_if.slave  bus
);

  // The one state an LFSR of this feedback polarity can never leave.
  localparam logic [WIDTH-1:0] LOCK    = XNOR ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] q_r;         // current state
  logic [WIDTH-1:0] ref_r;       // last loaded seed; wrap is measured against it
  logic [WIDTH-1:0] step_cnt;    // steps taken since ref_r was last seen
  logic [WIDTH-1:0] period_r;
  logic             period_valid_r;
  logic             wrap_r;
  logic             lockup_r;
  logic [WIDTH-1:0] nxt;

  // -------------------------------------------------------------------------
  // Next-state function
  // -------------------------------------------------------------------------
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    nxt = '0;
    if (GALOIS) begin
      // Galois: the outgoing MSB is fed back into every tapped stage.
      logic t;
      t      = q_r[WIDTH-1];
      nxt[0] = t;
      for (int i = 1; i < WIDTH; i++) begin
        if (TAPS[i-1]) nxt[i] = XNOR ? ~(q_r[i-1] ^ t) : (q_r[i-1] ^ t);
        else           nxt[i] = q_r[i-1];
      end
    end else begin
      // Fibonacci: parity of the tapped stages is shifted in at bit 0.
      logic fb;
      fb  = ^(q_r & TAPS);
      if (XNOR) fb = ~fb;
      nxt = {q_r[WIDTH-2:0], fb};
    end
  end

  // -------------------------------------------------------------------------
  // State, period measurement and event pulses
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  // NOTE: asynchronous reset -- the whole block returns to its reset values
  // the moment rst_n falls, so a run in progress leaves no partial period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r            <= SEED;
      ref_r          <= SEED;
      step_cnt       <= '0;
      period_r       <= '0;
      period_valid_r <= 1'b0;
      wrap_r         <= 1'b0;
      lockup_r       <= 1'b0;
    end else begin
      // Pulses last one cycle unless re-armed below.
      wrap_r   <= 1'b0;
      lockup_r <= 1'b0;

      if (bus.load) begin
        // A new seed restarts the measurement; any earlier period no longer
        // describes the sequence now running.
        q_r            <= bus.seed_in;
        ref_r          <= bus.seed_in;
        step_cnt       <= '0;
        period_valid_r <= 1'b0;
      end else if (bus.en && (q_r == LOCK)) begin
        // Recovery replaces the step; the previous period stays reported.
        q_r      <= SEED;
        ref_r    <= SEED;
        step_cnt <= '0;
        lockup_r <= 1'b1;
      end else if (bus.en) begin
        q_r <= nxt;
        if (nxt == ref_r) begin
          wrap_r         <= 1'b1;
          period_r       <= step_cnt + 1'b1;
          period_valid_r <= 1'b1;
          step_cnt       <= '0;
        end else if (step_cnt != CNT_MAX) begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.q            = q_r;
  assign bus.msb          = q_r[WIDTH-1];
  assign bus.wrap_tick    = wrap_r;
  assign bus.lockup       = lockup_r;
  assign bus.period       = period_r;
  assign bus.period_valid = period_valid_r;

endmodule : lfsr_gen

// File: tb/tb_lfsr_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_gen -- scoreboard bench for lfsr_gen.
//
// Five instances cover the configurations of interest:
//   id 0  WIDTH=4  TAPS=C  Fibonacci XOR   (maximal, period 15)
//   id 1  WIDTH=4  TAPS=C  Fibonacci XNOR  (lock-up state all-1)
//   id 2  WIDTH=4  TAPS=9  Galois XOR      (maximal, period 15)
//   id 3  WIDTH=4  TAPS=F  Galois XOR      (non-maximal, period 5)
//   id 4  default parameters (WIDTH=19)
// Stimulus is issued on the falling edge together with the expected
// post-edge outputs; a monitor pops them just after each rising edge.
// ---------------------------------------------------------------------------
module tb_lfsr_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_gen_if #(.WIDTH(4))  if0 ();
  lfsr_gen_if #(.WIDTH(4))  if1 ();
  lfsr_gen_if #(.WIDTH(4))  if2 ();
  lfsr_gen_if #(.WIDTH(4))  if3 ();
  lfsr_gen_if #(.WIDTH(19)) if4 ();

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .GALOIS(1'b0), .XNOR(1'b0))
    u_fib  (.clk(clk), .rst_n(rst_n), .bus(if0));
  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .GALOIS(1'b0), .XNOR(1'b1))
    u_xnor (.clk(clk), .rst_n(rst_n), .bus(if1));
  lfsr_gen #(.WIDTH(4), .TAPS(4'h9), .SEED(4'h1), .GALOIS(1'b1), .XNOR(1'b0))
    u_gal  (.clk(clk), .rst_n(rst_n), .bus(if2));
  lfsr_gen #(.WIDTH(4), .TAPS(4'hF), .SEED(4'h1), .GALOIS(1'b1), .XNOR(1'b0))
    u_galn (.clk(clk), .rst_n(rst_n), .bus(if3));
  lfsr_gen u_def (.clk(clk), .rst_n(rst_n), .bus(if4));

  typedef struct {
    int          id;
    logic [31:0] q;
    logic        wrap;
    logic        lock;
    logic        pv;
    logic [31:0] period;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0] q;
    logic        msb;
    logic        wrap;
    logic        lock;
    logic        pv;
    logic [31:0] period;
  } obs_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic int width_of(int id);
    return (id == 4) ? 19 : 4;
  endfunction

  function automatic obs_t observe(int id);
    obs_t o;
    case (id)
      0: o = '{32'(if0.q), if0.msb, if0.wrap_tick, if0.lockup, if0.period_valid, 32'(if0.period)};
      1: o = '{32'(if1.q), if1.msb, if1.wrap_tick, if1.lockup, if1.period_valid, 32'(if1.period)};
      2: o = '{32'(if2.q), if2.msb, if2.wrap_tick, if2.lockup, if2.period_valid, 32'(if2.period)};
      3: o = '{32'(if3.q), if3.msb, if3.wrap_tick, if3.lockup, if3.period_valid, 32'(if3.period)};
      default: o = '{32'(if4.q), if4.msb, if4.wrap_tick, if4.lockup, if4.period_valid, 32'(if4.period)};
    endcase
    return o;
  endfunction

  task automatic check(input exp_t e, input obs_t o);
    logic exp_msb;
    exp_msb = e.q[width_of(e.id)-1];
    n_checks++;
    if (o.q === e.q && o.msb === exp_msb && o.wrap === e.wrap && o.lock === e.lock &&
        o.pv === e.pv && o.period === e.period) begin
      n_pass++;
    end else begin
      $display("FAIL %s (dut %0d): got q=%h msb=%b wrap=%b lock=%b pv=%b period=%0d, want q=%h msb=%b wrap=%b lock=%b pv=%b period=%0d",
               e.name, e.id, o.q, o.msb, o.wrap, o.lock, o.pv, o.period,
               e.q, exp_msb, e.wrap, e.lock, e.pv, e.period);
    end
  endtask

  // Monitor: every entry queued before this edge describes the outputs now.
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e, observe(e.id));
    end
  end

  task automatic clear_inputs();
    if0.en = 1'b0; if0.load = 1'b0; if0.seed_in = '0;
    if1.en = 1'b0; if1.load = 1'b0; if1.seed_in = '0;
    if2.en = 1'b0; if2.load = 1'b0; if2.seed_in = '0;
    if3.en = 1'b0; if3.load = 1'b0; if3.seed_in = '0;
    if4.en = 1'b0; if4.load = 1'b0; if4.seed_in = '0;
  endtask

  task automatic expect_out(input int id, input logic [31:0] q, input logic wrap,
                            input logic lock, input logic pv, input logic [31:0] period,
                            input string name);
    exp_t e;
    e = '{id, q, wrap, lock, pv, period, name};
    sb.push_back(e);
  endtask

  // One clock of stimulus for one instance plus its expected result.
  task automatic cyc(input int id, input logic en, input logic load, input logic [31:0] seed,
                     input logic [31:0] q, input logic wrap, input logic lock,
                     input logic pv, input logic [31:0] period, input string name);
    @(negedge clk);
    clear_inputs();
    case (id)
      0: begin if0.en = en; if0.load = load; if0.seed_in = seed[3:0];  end
      1: begin if1.en = en; if1.load = load; if1.seed_in = seed[3:0];  end
      2: begin if2.en = en; if2.load = load; if2.seed_in = seed[3:0];  end
      3: begin if3.en = en; if3.load = load; if3.seed_in = seed[3:0];  end
      default: begin if4.en = en; if4.load = load; if4.seed_in = seed[18:0]; end
    endcase
    expect_out(id, q, wrap, lock, pv, period, name);
  endtask

  // Hand-computed state sequences (the value after each step from seed 1).
  logic [3:0]  t1_seq [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                               4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
  logic [3:0]  t5_seq [15] = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
                               4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
  logic [3:0]  t5n_seq [5] = '{4'h2, 4'h4, 4'h8, 4'hF, 4'h1};
  logic [18:0] def_seq [6] = '{19'h00003, 19'h00006, 19'h0000D, 19'h0001B,
                               19'h00036, 19'h0006C};

  initial begin
    clear_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state of every instance, observed over one idle cycle.
    @(negedge clk);
    for (int id = 0; id < 5; id++) expect_out(id, 32'h1, 1'b0, 1'b0, 1'b0, 32'd0, "reset_state");

    // T1: maximal Fibonacci, 15 steps back to the seed.
    for (int k = 0; k < 15; k++)
      cyc(0, 1'b1, 1'b0, 32'd0, 32'(t1_seq[k]), (k == 14), 1'b0, (k == 14),
          (k == 14) ? 32'd15 : 32'd0, "t1_step");
    cyc(0, 1'b0, 1'b0, 32'd0, 32'h1, 1'b0, 1'b0, 1'b1, 32'd15, "t1_idle_hold");

    // T3: load the lock-up seed; it holds while idle, recovers on en.
    cyc(0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd15, "t3_load_lock");
    cyc(0, 1'b0, 1'b0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd15, "t3_lock_idle");
    cyc(0, 1'b1, 1'b0, 32'd0, 32'h1, 1'b0, 1'b1, 1'b0, 32'd15, "t3_recover");
    cyc(0, 1'b1, 1'b0, 32'd0, 32'h2, 1'b0, 1'b0, 1'b0, 32'd15, "t3_step_after");

    // T6: load beats en at step 5, then an asynchronous reset mid-cycle.
    cyc(0, 1'b0, 1'b1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 32'd15, "t6_reload");
    for (int k = 0; k < 5; k++)
      cyc(0, 1'b1, 1'b0, 32'd0, 32'(t1_seq[k]), 1'b0, 1'b0, 1'b0, 32'd15, "t6_step");
    cyc(0, 1'b1, 1'b1, 32'h7, 32'h7, 1'b0, 1'b0, 1'b0, 32'd15, "t6_load_wins");
    cyc(0, 1'b1, 1'b0, 32'd0, 32'hF, 1'b0, 1'b0, 1'b0, 32'd15, "t6_step_from_load");
    cyc(0, 1'b0, 1'b0, 32'd0, 32'h1, 1'b0, 1'b0, 1'b0, 32'd0, "t6_after_reset");
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;

    // T4: XNOR feedback, all-1 is the lock-up state, all-0 is legal.
    cyc(1, 1'b0, 1'b1, 32'hF, 32'hF, 1'b0, 1'b0, 1'b0, 32'd0, "t4_load_ones");
    cyc(1, 1'b1, 1'b0, 32'd0, 32'h1, 1'b0, 1'b1, 1'b0, 32'd0, "t4_recover");
    cyc(1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, "t4_load_zero");
    cyc(1, 1'b1, 1'b0, 32'd0, 32'h1, 1'b0, 1'b0, 1'b0, 32'd0, "t4_zero_steps");
    cyc(1, 1'b1, 1'b0, 32'd0, 32'h3, 1'b0, 1'b0, 1'b0, 32'd0, "t4_next_step");

    // T5: Galois maximal mask, then a non-maximal one.
    for (int k = 0; k < 15; k++)
      cyc(2, 1'b1, 1'b0, 32'd0, 32'(t5_seq[k]), (k == 14), 1'b0, (k == 14),
          (k == 14) ? 32'd15 : 32'd0, "t5_galois_step");
    for (int k = 0; k < 5; k++)
      cyc(3, 1'b1, 1'b0, 32'd0, 32'(t5n_seq[k]), (k == 4), 1'b0, (k == 4),
          (k == 4) ? 32'd5 : 32'd0, "t5_nonmax_step");

    // Default 19-bit configuration: first steps, serial output, top-bit seed.
    for (int k = 0; k < 6; k++)
      cyc(4, 1'b1, 1'b0, 32'd0, 32'(def_seq[k]), 1'b0, 1'b0, 1'b0, 32'd0, "def_step");
    cyc(4, 1'b0, 1'b1, 32'h40000, 32'h40000, 1'b0, 1'b0, 1'b0, 32'd0, "def_load_msb");
    cyc(4, 1'b1, 1'b0, 32'd0, 32'h00001, 1'b0, 1'b0, 1'b0, 32'd0, "def_msb_out");
    cyc(4, 1'b1, 1'b0, 32'd0, 32'h00003, 1'b0, 1'b0, 1'b0, 32'd0, "def_step_on");

    @(negedge clk);
    clear_inputs();
    repeat (2) @(negedge clk);

    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation time %0t, want completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_lfsr_gen
